hms_multimode_clock: RTL and testbench
======================================

# hms_multimode_clock

Parametrised successor of the team's seconds/minutes/hours clock: a time-of-day counter plus an independent up/down stopwatch, driven by an internal prescaler rather than gated clocks. A four-state mode FSM selects what the display outputs show and lets the user set hours and minutes. The block sits directly under the board top level, between the debounced push-buttons and the seven-segment driver.

## Interface
- DIV, 1000: clk cycles per one-second tick, at least 2.
- H24, 1: 1 selects 24-hour display; 0 selects 12-hour display with `pm_o`.
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode_btn  in  1  debounced level; each rising edge advances the mode.
- start_stop  in  1  debounced level; rising edge toggles stopwatch run (SW mode only).
- clear  in  1  level; zeroes the stopwatch and forces it stopped (SW mode only).
- ud  in  1  stopwatch direction: 1 counts up, 0 counts down.
- inc  in  1  debounced level; rising edge increments the field being set.
- sec_o  out  6  displayed seconds.
- min_o  out  6  displayed minutes.
- hour_o  out  5  displayed hours.
- pm_o  out  1  PM flag; always 0 when H24=1.
- mode_o  out  2  current mode.
- sw_done  out  1  one-cycle pulse when a down-count reaches zero.
- tick_o  out  1  one-cycle one-second tick.

## Operation
- Prescaler: counts 0..DIV-1. `tick_o` is high for the single cycle where the count equals DIV-1.
- Edge detection: `mode_btn`, `start_stop` and `inc` each have a previous-value register. An edge is `in & ~prev`.
- Mode FSM: CLK(0) → SW(1) → SET_H(2) → SET_M(3) → CLK on each `mode_btn` edge.
- Display mux: SW mode shows the stopwatch; the other three modes show time-of-day.
- Time-of-day:
  - Seconds wrap 59→0 with carry to minutes; minutes wrap 59→0 with carry to hours; hours wrap 23→0.
  - It counts up on every tick while in CLK or SW mode.
  - In SET_H and SET_M it is frozen.
  - Entering SET_H zeroes the seconds.
- Setting: an `inc` edge in SET_H gives hour+1 (23→0). An `inc` edge in SET_M gives minute+1 (59→0) with no carry into hours.
- Stopwatch counting: it runs in the background in every mode whenever run=1, and advances one second per tick.
  - Up: 23:59:59 wraps to 00:00:00.
  - Down: borrows 00→59 and 00→23 like the counter it replaces.
  - Down, stepping from 00:00:01 to 00:00:00: run clears and `sw_done` pulses in the same cycle the zero value is loaded.
- Stopwatch controls:
  - A `start_stop` edge with ud=0 and the value already 00:00:00: run stays 0 and there is no pulse.
  - `clear` beats `start_stop` in the same cycle.
  - `ud` may change mid-run; it takes effect on the next tick.
- 12-hour display (H24=0): internal hour h is always 0..23.
  - Displayed hour_o is 12 for h=0, h for 1..12, h-12 for 13..23.
  - pm_o = (h ≥ 12).

## Timing
- Reset values: all outputs 0, mode CLK, run 0, prescaler 0, edge registers 0.
  - With H24=0, hour_o resets to 12.
- Latency: all outputs are registered. A tick or edge sampled at clock edge N is visible after edge N+1.
- The first tick occurs DIV cycles after reset deasserts.
- Simultaneous events:
  - A tick and a `start_stop` edge in the same cycle: the tick uses the old run value, and the toggle is applied as well.
  - A tick and an `inc` edge in SET mode: only the increment applies.
  - A tick and a `mode_btn` edge: the tick uses the old mode.
- Reset mid-operation clears everything immediately, asynchronously. There is no partial state.

## Structure
- Package `clock_pkg`:
  - mode enum {CLK, SW, SET_H, SET_M}
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
  - widths 6/6/5
- Sub-module `hms_counter`:
  - Contents: sec/min/hour registers with `en`, `ud`, `clr`, `inc_h`, `inc_m`, `zero_sec` inputs.
  - Outputs: the three fields plus `is_zero`.
  - Instantiated twice: once for time-of-day, once for the stopwatch.
- The top holds the prescaler, edge detectors, mode FSM, run flag, 12-hour conversion and display mux.

## Test plan
- Reset, DIV=4, H24=1: outputs are 0. After 4×60 cycles in CLK mode, min_o=1 and sec_o=0.
- Preload 23:59:59 via SET modes plus ticks. The next tick → 00:00:00 with no glitch on the intermediate fields.
- SW mode, ud=0:
  - Set the stopwatch to 00:00:02 by counting up, stop it, set ud=0, restart.
  - After two ticks → 00:00:00, sw_done high for exactly 1 cycle, run=0, and further ticks leave 0.
- H24=0: hour 0 → hour_o=12, pm_o=0; hour 13 → hour_o=1, pm_o=1; hour 12 → hour_o=12, pm_o=1.
- SET_M at minute 59, `inc` edge → minute 0 and hour unchanged. The same cycle as a tick still gives only +1 minute.
- Assert rst mid-count in SW mode with run=1 → every output is 0 asynchronously, mode=CLK, and after release the stopwatch stays stopped.

Source files
------------

// File: rtl/hms_multimode_clock_pkg.sv
// Shared types and limits for the multimode time-of-day / stopwatch clock.
// Field widths and wrap limits are common to both hms_counter instances.
package clock_pkg;

  typedef enum logic [1:0] {
    CLK   = 2'd0,
    SW    = 2'd1,
    SET_H = 2'd2,
    SET_M = 2'd3
  } mode_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);

endpackage

// File: rtl/hms_multimode_clock_counter.sv
// Hours/minutes/seconds register set with up/down stepping and field setting.
// Used both as the time-of-day counter and as the stopwatch.
module hms_counter
  import clock_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_ud,
  input  logic              i_clr,
  input  logic              i_incH,
  input  logic              i_incM,
  input  logic              i_zeroSec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_isZero
);

  logic [SEC_W-1:0]  r_sec, w_secNext;
  logic [MIN_W-1:0]  r_min, w_minNext;
  logic [HOUR_W-1:0] r_hour, w_hourNext;

  // Setting beats counting; zeroing the seconds is applied last so it wins.
  always_comb begin
    w_secNext  = r_sec;
    w_minNext  = r_min;
    w_hourNext = r_hour;
    if (i_clr) begin
      w_secNext  = '0;
      w_minNext  = '0;
      w_hourNext = '0;
    end else begin
      if (i_incH) begin
        w_hourNext = (r_hour == HOUR_MAX) ? '0 : r_hour + HOUR_W'(1);
      end else if (i_incM) begin
        w_minNext = (r_min == MIN_MAX) ? '0 : r_min + MIN_W'(1);
      end else if (i_en) begin
        if (i_ud) begin
          if (r_sec == SEC_MAX) begin
            w_secNext = '0;
            if (r_min == MIN_MAX) begin
              w_minNext  = '0;
              w_hourNext = (r_hour == HOUR_MAX) ? '0 : r_hour + HOUR_W'(1);
            end else begin
              w_minNext = r_min + MIN_W'(1);
            end
          end else begin
            w_secNext = r_sec + SEC_W'(1);
          end
        end else begin
          if (r_sec == '0) begin
            w_secNext = SEC_MAX;
            if (r_min == '0) begin
              w_minNext  = MIN_MAX;
              w_hourNext = (r_hour == '0) ? HOUR_MAX : r_hour - HOUR_W'(1);
            end else begin
              w_minNext = r_min - MIN_W'(1);
            end
          end else begin
            w_secNext = r_sec - SEC_W'(1);
          end
        end
      end
      if (i_zeroSec) begin
        w_secNext = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
    end else begin
      r_sec  <= w_secNext;
      r_min  <= w_minNext;
      r_hour <= w_hourNext;
    end
  end

  assign o_sec    = r_sec;
  assign o_min    = r_min;
  assign o_hour   = r_hour;
  assign o_isZero = (r_sec == '0) && (r_min == '0) && (r_hour == '0);

endmodule

// File: rtl/hms_multimode_clock.sv
// Time-of-day clock plus background up/down stopwatch, a four-mode user FSM,
// one-second prescaler and optional 12-hour display conversion.
module hms_multimode_clock
  import clock_pkg::*;
#(
  parameter int DIV = 1000,
  parameter bit H24 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_btn,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              ud,
  input  logic              inc,
  output logic [SEC_W-1:0]  sec_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [HOUR_W-1:0] hour_o,
  output logic              pm_o,
  output logic [1:0]        mode_o,
  output logic              sw_done,
  output logic              tick_o
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] TICK_PRE   = PW'(DIV - 2);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_prevMode, r_prevSs, r_prevInc;
  mode_t         r_mode, w_modeNext;
  logic          r_run, w_runNext;
  logic          r_swDone;

  logic w_modeEdge, w_ssEdge, w_incEdge;
  logic w_todEn, w_todIncH, w_todIncM, w_todZeroSec;
  logic w_swClr, w_swEn, w_swIsOne, w_swIsZero, w_reachZero;

  logic [SEC_W-1:0]  w_todSec, w_swSec, w_selSec, r_sec;
  logic [MIN_W-1:0]  w_todMin, w_swMin, w_selMin, r_min;
  logic [HOUR_W-1:0] w_todHour, w_swHour, w_selHour, w_dispHour, r_hour;
  logic              w_dispPm, r_pm;

  // The tick is registered one count early so it is high while the count is DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc    <= '0;
      r_tick     <= 1'b0;
      r_prevMode <= 1'b0;
      r_prevSs   <= 1'b0;
      r_prevInc  <= 1'b0;
    end else begin
      r_presc    <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      r_tick     <= (r_presc == TICK_PRE);
      r_prevMode <= mode_btn;
      r_prevSs   <= start_stop;
      r_prevInc  <= inc;
    end
  end

  assign w_modeEdge = mode_btn & ~r_prevMode;
  assign w_ssEdge   = start_stop & ~r_prevSs;
  assign w_incEdge  = inc & ~r_prevInc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= CLK;
    end else begin
      r_mode <= w_modeNext;
    end
  end

  always_comb begin
    w_modeNext = r_mode;
    if (w_modeEdge) begin
      case (r_mode)
        CLK:     w_modeNext = SW;
        SW:      w_modeNext = SET_H;
        SET_H:   w_modeNext = SET_M;
        default: w_modeNext = CLK;
      endcase
    end
  end

  // All controls decode the pre-edge mode and run flag, which gives the
  // "old value" behaviour for simultaneous tick/button events.
  always_comb begin
    w_todEn      = r_tick & ((r_mode == CLK) | (r_mode == SW));
    w_todIncH    = w_incEdge & (r_mode == SET_H);
    w_todIncM    = w_incEdge & (r_mode == SET_M);
    w_todZeroSec = w_modeEdge & (r_mode == SW);
    w_swClr      = clear & (r_mode == SW);
    w_swEn       = r_tick & r_run;
    w_swIsOne    = (w_swSec == SEC_W'(1)) && (w_swMin == '0) && (w_swHour == '0);
    w_reachZero  = w_swEn & ~ud & w_swIsOne & ~w_swClr;
    w_runNext    = r_run;
    if (w_swClr) begin
      w_runNext = 1'b0;
    end else if (w_ssEdge && (r_mode == SW)) begin
      w_runNext = ~r_run & ~(~ud & w_swIsZero);
    end else if (w_reachZero) begin
      w_runNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run    <= 1'b0;
      r_swDone <= 1'b0;
    end else begin
      r_run    <= w_runNext;
      r_swDone <= w_reachZero;
    end
  end

  hms_counter u_tod (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_todEn),
    .i_ud      (1'b1),
    .i_clr     (1'b0),
    .i_incH    (w_todIncH),
    .i_incM    (w_todIncM),
    .i_zeroSec (w_todZeroSec),
    .o_sec     (w_todSec),
    .o_min     (w_todMin),
    .o_hour    (w_todHour),
    .o_isZero  ()
  );

  hms_counter u_sw (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_swEn),
    .i_ud      (ud),
    .i_clr     (w_swClr),
    .i_incH    (1'b0),
    .i_incM    (1'b0),
    .i_zeroSec (1'b0),
    .o_sec     (w_swSec),
    .o_min     (w_swMin),
    .o_hour    (w_swHour),
    .o_isZero  (w_swIsZero)
  );

  always_comb begin
    w_selSec   = (r_mode == SW) ? w_swSec  : w_todSec;
    w_selMin   = (r_mode == SW) ? w_swMin  : w_todMin;
    w_selHour  = (r_mode == SW) ? w_swHour : w_todHour;
    w_dispHour = w_selHour;
    w_dispPm   = 1'b0;
    if (!H24) begin
      w_dispPm = (w_selHour >= HOUR_W'(12));
      if (w_selHour == '0) begin
        w_dispHour = HOUR_W'(12);
      end else if (w_selHour > HOUR_W'(12)) begin
        w_dispHour = w_selHour - HOUR_W'(12);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= H24 ? '0 : HOUR_W'(12);
      r_pm   <= 1'b0;
    end else begin
      r_sec  <= w_selSec;
      r_min  <= w_selMin;
      r_hour <= w_dispHour;
      r_pm   <= w_dispPm;
    end
  end

  assign sec_o   = r_sec;
  assign min_o   = r_min;
  assign hour_o  = r_hour;
  assign pm_o    = r_pm;
  assign mode_o  = r_mode;
  assign sw_done = r_swDone;
  assign tick_o  = r_tick;

endmodule

// File: tb/tb_hms_multimode_clock.sv
// Scoreboard bench: a seconds-since-midnight reference model predicts every
// cycle's outputs for a 24-hour and a 12-hour instance driven in parallel.
module tb_hms_multimode_clock;

  localparam int DIV = 4;
  localparam int DAY = 86400;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       pm;
    logic [1:0] mode;
    logic       done;
    logic       tick;
  } obs_t;

  typedef struct {
    obs_t a;
    obs_t b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic modeBtn = 1'b0, startStop = 1'b0, clear = 1'b0, ud = 1'b1, inc = 1'b0;

  logic [5:0] secA, minA, secB, minB;
  logic [4:0] hourA, hourB;
  logic [1:0] modeA, modeB;
  logic       pmA, pmB, doneA, doneB, tickA, tickB;
  obs_t       obsA, obsB;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  int mTod, mSw, mMode, mCyc;
  bit mRun, pMb, pSs, pInc;
  bit udDrv = 1'b1;

  hms_multimode_clock #(.DIV(DIV), .H24(1'b1)) dutA (
    .clk(clk), .rst(rst), .mode_btn(modeBtn), .start_stop(startStop),
    .clear(clear), .ud(ud), .inc(inc),
    .sec_o(secA), .min_o(minA), .hour_o(hourA), .pm_o(pmA),
    .mode_o(modeA), .sw_done(doneA), .tick_o(tickA)
  );

  hms_multimode_clock #(.DIV(DIV), .H24(1'b0)) dutB (
    .clk(clk), .rst(rst), .mode_btn(modeBtn), .start_stop(startStop),
    .clear(clear), .ud(ud), .inc(inc),
    .sec_o(secB), .min_o(minB), .hour_o(hourB), .pm_o(pmB),
    .mode_o(modeB), .sw_done(doneB), .tick_o(tickB)
  );

  assign obsA = {secA, minA, hourA, pmA, modeA, doneA, tickA};
  assign obsB = {secB, minB, hourB, pmB, modeB, doneB, tickB};

  always #5 clk = ~clk;

  function automatic obs_t dispObs(input bit h24, input int t);
    obs_t o;
    int   h;
    h = t / 3600;
    o = '0;
    o.sec = 6'(t % 60);
    o.min = 6'((t / 60) % 60);
    if (h24) begin
      o.hour = 5'(h);
    end else begin
      o.hour = 5'((h == 0) ? 12 : ((h > 12) ? h - 12 : h));
      o.pm   = (h >= 12);
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got sec=%0d min=%0d hour=%0d pm=%0d mode=%0d done=%0d tick=%0d, expected sec=%0d min=%0d hour=%0d pm=%0d mode=%0d done=%0d tick=%0d",
               name, $time, act.sec, act.min, act.hour, act.pm, act.mode, act.done, act.tick,
               exp.sec, exp.min, exp.hour, exp.pm, exp.mode, exp.done, exp.tick);
    end
  endtask

  task automatic modelReset();
    mTod = 0; mSw = 0; mMode = 0; mCyc = 0;
    mRun = 0; pMb = 0; pSs = 0; pInc = 0;
  endtask

  // Predict the outputs visible after the coming rising edge from the rules
  // of the clock, using whole seconds since midnight for both counters.
  task automatic modelStep();
    exp_t e;
    bit   tick, meE, ssE, incE, clrE, done, newRun;
    int   oldSw, shown;
    tick  = (mCyc % DIV) == DIV - 1;
    shown = (mMode == 1) ? mSw : mTod;
    e.a   = dispObs(1'b1, shown);
    e.b   = dispObs(1'b0, shown);
    meE   = modeBtn && !pMb;
    ssE   = startStop && !pSs;
    incE  = inc && !pInc;
    if ((mMode == 0 || mMode == 1) && tick) mTod = (mTod + 1) % DAY;
    if (mMode == 2 && incE) mTod = (((mTod / 3600) + 1) % 24) * 3600 + mTod % 3600;
    if (mMode == 3 && incE)
      mTod = (mTod / 3600) * 3600 + ((((mTod / 60) % 60) + 1) % 60) * 60 + mTod % 60;
    if (meE && mMode == 1) mTod = mTod - mTod % 60;
    clrE  = clear && (mMode == 1);
    oldSw = mSw;
    done  = !clrE && mRun && tick && !ud && oldSw == 1;
    if (clrE) mSw = 0;
    else if (mRun && tick) mSw = ud ? (mSw + 1) % DAY : (mSw + DAY - 1) % DAY;
    if (clrE) newRun = 0;
    else if (ssE && mMode == 1) newRun = !mRun && !(!ud && oldSw == 0);
    else if (done) newRun = 0;
    else newRun = mRun;
    mRun = newRun;
    if (meE) mMode = (mMode + 1) % 4;
    pMb = modeBtn; pSs = startStop; pInc = inc;
    mCyc++;
    e.a.mode = 2'(mMode); e.b.mode = 2'(mMode);
    e.a.done = done;      e.b.done = done;
    e.a.tick = (mCyc % DIV) == DIV - 1;
    e.b.tick = e.a.tick;
    expQ.push_back(e);
  endtask

  // Called at a falling edge: drive one cycle of inputs and predict its effect.
  task automatic applyStimulus(input bit mb, input bit ss, input bit cl, input bit in);
    modeBtn = mb; startStop = ss; clear = cl; inc = in; ud = udDrv;
    modelStep();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
  endtask

  task automatic pressMode();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic pressSs();
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic pressInc();
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic gotoMode(input int target);
    for (int k = 0; k < 4; k++) if (mMode != target) pressMode();
  endtask

  task automatic alignTick();
    for (int k = 0; k < DIV; k++) if ((mCyc % DIV) != DIV - 1) idle(1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst && expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("cycle24", obsA, e.a);
        checkOutput("cycle12", obsB, e.b);
      end
    end
  end

  initial begin
    obs_t rstA, rstB;
    rstA = '0;
    rstB = '0;
    rstB.hour = 5'd12;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset24", obsA, rstA);
    checkOutput("reset12", obsB, rstB);
    rst = 1'b1;

    // A full minute of ticks in CLK mode.
    idle(DIV * 60 + 2);

    // Set 23:59 (entering SET_H zeroes seconds) and step every hour display.
    gotoMode(2);
    for (int i = 0; i < 24; i++) if (mTod / 3600 != 23) pressInc();
    gotoMode(3);
    for (int i = 0; i < 60; i++) if ((mTod / 60) % 60 != 59) pressInc();
    // Increment coinciding with a tick: 59 -> 0 without hour carry, then back to 59.
    alignTick();
    pressInc();
    for (int i = 0; i < 60; i++) if ((mTod / 60) % 60 != 59) begin alignTick(); pressInc(); end
    gotoMode(0);
    idle(DIV * 62);

    // Stopwatch: count up to 2, stop, count down to zero, then try to restart at zero.
    gotoMode(1);
    applyStimulus(0, 0, 1, 0);
    udDrv = 1'b1;
    pressSs();
    for (int i = 0; i < 100; i++) if (mSw < 2) idle(1);
    pressSs();
    udDrv = 1'b0;
    idle(2);
    pressSs();
    idle(DIV * 5);
    pressSs();
    idle(DIV * 3);
    udDrv = 1'b1;
    applyStimulus(0, 1, 1, 0);
    idle(DIV * 2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) udDrv = ~udDrv;
      applyStimulus($urandom_range(9) == 0, $urandom_range(5) == 0,
                    $urandom_range(24) == 0, $urandom_range(3) == 0);
    end

    // Asynchronous reset while the stopwatch runs in SW mode.
    idle(2);
    gotoMode(1);
    udDrv = 1'b1;
    if (!mRun) pressSs();
    idle(DIV * 3 + 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncReset24", obsA, rstA);
    checkOutput("asyncReset12", obsB, rstB);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(5);
    gotoMode(1);
    idle(DIV * 4);

    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL queueDrain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
